// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: data RAM loads and stores, two memory-mapped
// I/O words and a registered write-back packet one cycle after each accepted packet.
module mem_wb_stage #(
  parameter int unsigned       DATA_W      = 16,
  parameter int unsigned       ADDR_W      = 8,
  parameter logic [DATA_W-1:0] IO_OUT_ADDR = 16'hFFFF,
  parameter logic [DATA_W-1:0] IO_IN_ADDR  = 16'hFFFE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_ex,
  input  logic [5:0]        op_ex,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic [1:0]        flag_ex,
  input  logic [3:0]        rd_ex,
  input  logic              wr_ex,
  input  logic [DATA_W-1:0] io_in,
  output logic              wb_en,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic [1:0]        flag_wb,
  output logic [DATA_W-1:0] io_out,
  output logic              addr_err
);

  localparam int unsigned RAM_WORDS = 2 ** ADDR_W;
  localparam logic [5:0]  OP_LOAD   = 6'b010100;
  localparam logic [5:0]  OP_STORE  = 6'b010101;

  logic [DATA_W-1:0] ram [RAM_WORDS];

  logic              hit_io_out_c;
  logic              hit_io_in_c;
  logic              hit_ram_c;
  logic              out_of_range_c;
  logic [ADDR_W-1:0] ram_idx_c;
  logic [DATA_W-1:0] load_val_c;
  logic              is_load_c;
  logic              is_store_c;

  // Address decode: I/O words take priority over the RAM window.
  always_comb begin
    hit_io_out_c   = (ans_ex == IO_OUT_ADDR);
    hit_io_in_c    = (ans_ex == IO_IN_ADDR);
    hit_ram_c      = !hit_io_out_c && !hit_io_in_c && (32'(ans_ex) < RAM_WORDS);
    out_of_range_c = !hit_io_out_c && !hit_io_in_c && !hit_ram_c;
    ram_idx_c      = ans_ex[ADDR_W-1:0];
    is_load_c      = valid_ex && (op_ex == OP_LOAD);
    is_store_c     = valid_ex && (op_ex == OP_STORE);
  end

  // Value a LOAD would return; registered into wb_data at the same edge.
  always_comb begin
    load_val_c = '0;
    if (hit_ram_c)         load_val_c = ram[ram_idx_c];
    else if (hit_io_in_c)  load_val_c = io_in;
    else if (hit_io_out_c) load_val_c = io_out;
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && is_store_c && hit_ram_c) begin
      ram[ram_idx_c] <= DM_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      flag_wb  <= '0;
      io_out   <= '0;
      addr_err <= 1'b0;
    end else begin
      wb_en <= 1'b0;
      if (is_store_c) begin
        if (hit_io_out_c)                    io_out   <= DM_data;
        else if (hit_io_in_c || out_of_range_c) addr_err <= 1'b1;
      end else if (is_load_c) begin
        wb_data <= load_val_c;
        wb_en   <= wr_ex;
        wb_rd   <= rd_ex;
        flag_wb <= {(load_val_c == '0), 1'b0};
        if (out_of_range_c) addr_err <= 1'b1;
      end else if (valid_ex) begin
        wb_data <= ans_ex;
        wb_en   <= wr_ex;
        wb_rd   <= rd_ex;
        flag_wb <= flag_ex;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expected values.
module tb_mem_wb_stage;

  localparam logic [5:0] OP_LOAD  = 6'b010100;
  localparam logic [5:0] OP_STORE = 6'b010101;
  localparam logic [5:0] OP_ALU   = 6'b000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_ex;
  logic [5:0]  op_ex;
  logic [15:0] ans_ex;
  logic [15:0] DM_data;
  logic [1:0]  flag_ex;
  logic [3:0]  rd_ex;
  logic        wr_ex;
  logic [15:0] io_in;
  logic        wb_en;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic [1:0]  flag_wb;
  logic [15:0] io_out;
  logic        addr_err;

  int n_vec = 0;
  int n_err = 0;

  mem_wb_stage dut (
    .clk      (clk),
    .reset    (reset),
    .valid_ex (valid_ex),
    .op_ex    (op_ex),
    .ans_ex   (ans_ex),
    .DM_data  (DM_data),
    .flag_ex  (flag_ex),
    .rd_ex    (rd_ex),
    .wr_ex    (wr_ex),
    .io_in    (io_in),
    .wb_en    (wb_en),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .flag_wb  (flag_wb),
    .io_out   (io_out),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pkt(input logic v, input logic [5:0] op, input logic [15:0] ans,
                     input logic [15:0] dm, input logic [1:0] flg,
                     input logic [3:0] rd, input logic wr);
    valid_ex = v;
    op_ex    = op;
    ans_ex   = ans;
    DM_data  = dm;
    flag_ex  = flg;
    rd_ex    = rd;
    wr_ex    = wr;
  endtask

  // Advance one edge and settle so outputs reflect the packet just sampled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    io_in = 16'h0000;
    pkt(1'b0, OP_ALU, 16'h0, 16'h0, 2'b00, 4'd0, 1'b0);
    #1;

    // Preload RAM before reset so the post-reset LOAD has a known value
    pkt(1'b1, OP_STORE, 16'h0010, 16'h1111, 2'b00, 4'd0, 1'b0); step();
    pkt(1'b1, OP_STORE, 16'h0020, 16'h0000, 2'b00, 4'd0, 1'b0); step();

    reset = 1'b1;
    pkt(1'b1, OP_STORE, 16'h0010, 16'hBEEF, 2'b00, 4'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_wb_en", 32'(wb_en), 32'd0);
      check("rst_io_out", 32'(io_out), 32'd0);
      check("rst_addr_err", 32'(addr_err), 32'd0);
    end
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_flag_wb", 32'(flag_wb), 32'd0);
    reset = 1'b0;

    pkt(1'b1, OP_LOAD, 16'h0010, 16'h0, 2'b00, 4'd1, 1'b1); step();
    check("rst_nowrite_data", 32'(wb_data), 32'h1111);
    check("rst_nowrite_en", 32'(wb_en), 32'd1);

    // Store then load the same address on consecutive cycles
    pkt(1'b1, OP_STORE, 16'h0005, 16'h1234, 2'b00, 4'd9, 1'b1); step();
    check("st_wb_en", 32'(wb_en), 32'd0);
    pkt(1'b1, OP_LOAD, 16'h0005, 16'h0, 2'b11, 4'd3, 1'b1); step();
    check("ld_wb_en", 32'(wb_en), 32'd1);
    check("ld_wb_rd", 32'(wb_rd), 32'd3);
    check("ld_wb_data", 32'(wb_data), 32'h1234);
    check("ld_flag_wb", 32'(flag_wb), 32'd0);

    pkt(1'b1, OP_ALU, 16'h0000, 16'h0, 2'b11, 4'd7, 1'b1); step();
    check("alu_wb_data", 32'(wb_data), 32'd0);
    check("alu_wb_rd", 32'(wb_rd), 32'd7);
    check("alu_wb_en", 32'(wb_en), 32'd1);
    check("alu_flag_wb", 32'(flag_wb), 32'd3);
    pkt(1'b1, OP_STORE, 16'h0006, 16'h0009, 2'b00, 4'd2, 1'b1); step();
    check("st_flag_hold", 32'(flag_wb), 32'd3);
    check("st_rd_hold", 32'(wb_rd), 32'd7);
    check("st_en_low", 32'(wb_en), 32'd0);

    // Memory-mapped I/O
    pkt(1'b1, OP_STORE, 16'hFFFF, 16'hA5A5, 2'b00, 4'd0, 1'b0); step();
    check("io_out_wr", 32'(io_out), 32'hA5A5);
    check("io_out_err", 32'(addr_err), 32'd0);
    io_in = 16'h00C3;
    pkt(1'b1, OP_LOAD, 16'hFFFE, 16'h0, 2'b00, 4'd2, 1'b1); step();
    check("io_in_data", 32'(wb_data), 32'h00C3);
    check("io_in_flag", 32'(flag_wb), 32'd0);
    io_in = 16'h0000;
    pkt(1'b1, OP_LOAD, 16'hFFFF, 16'h0, 2'b00, 4'd4, 1'b1); step();
    check("io_out_rd", 32'(wb_data), 32'hA5A5);

    pkt(1'b0, OP_ALU, 16'h5555, 16'h0, 2'b11, 4'd8, 1'b1); step();
    check("idle_en", 32'(wb_en), 32'd0);
    check("idle_data", 32'(wb_data), 32'hA5A5);
    check("idle_rd", 32'(wb_rd), 32'd4);

    // Load of a zero word with wr_ex low
    pkt(1'b1, OP_LOAD, 16'h0020, 16'h0, 2'b01, 4'd4, 1'b0); step();
    check("zero_en", 32'(wb_en), 32'd0);
    check("zero_data", 32'(wb_data), 32'd0);
    check("zero_flag", 32'(flag_wb), 32'd2);

    // Out-of-range store must not alias onto RAM[0]
    pkt(1'b1, OP_STORE, 16'h0000, 16'h7777, 2'b00, 4'd0, 1'b0); step();
    pkt(1'b1, OP_STORE, 16'h0100, 16'hDEAD, 2'b00, 4'd0, 1'b0); step();
    check("oor_err_set", 32'(addr_err), 32'd1);
    pkt(1'b1, OP_LOAD, 16'h0000, 16'h0, 2'b00, 4'd5, 1'b1); step();
    check("oor_ram_kept", 32'(wb_data), 32'h7777);
    for (int i = 1; i <= 10; i++) begin
      pkt(1'b1, OP_ALU, 16'(i * 16'h0111), 16'h0, 2'(i), 4'(i), 1'b1); step();
      check("sticky_err", 32'(addr_err), 32'd1);
      check("sticky_data", 32'(wb_data), 32'(i * 32'h0111));
    end
    reset = 1'b1; step(); reset = 1'b0;
    check("err_clear", 32'(addr_err), 32'd0);
    check("io_out_clear", 32'(io_out), 32'd0);

    pkt(1'b1, OP_LOAD, 16'h0200, 16'h0, 2'b01, 4'd6, 1'b1); step();
    check("oor_ld_data", 32'(wb_data), 32'd0);
    check("oor_ld_flag", 32'(flag_wb), 32'd2);
    check("oor_ld_err", 32'(addr_err), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    pkt(1'b1, OP_STORE, 16'hFFFE, 16'h4321, 2'b00, 4'd0, 1'b0); step();
    check("st_ioin_err", 32'(addr_err), 32'd1);
    check("st_ioin_out", 32'(io_out), 32'd0);

    pkt(1'b0, OP_ALU, 16'h0, 16'h0, 2'b00, 4'd0, 1'b0); step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access/write-back stage that consumes the execute-stage results of the 16-bit processor: ALU result, store data, flags and the decoded opcode.
- Performs data-memory loads and stores against an internal synchronous RAM.
- Handles two memory-mapped I/O words.
- Presents a registered write-back packet to the register file one cycle after each accepted instruction.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 8, RAM address width (2**ADDR_W words).
- IO_OUT_ADDR, 16'hFFFF, store address mapped to the io_out register.
- IO_IN_ADDR, 16'hFFFE, load address mapped to io_in.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- valid_ex  in  1  execute-stage packet valid this cycle.
- op_ex  in  6  decoded opcode of the packet; LOAD=6'b010100, STORE=6'b010101.
- ans_ex  in  16  ALU result; the effective address for LOAD/STORE.
- DM_data  in  16  store data for STORE.
- flag_ex  in  2  ALU flags: [1] zero, [0] overflow.
- rd_ex  in  4  destination register index.
- wr_ex  in  1  packet writes a register (ignored for STORE).
- io_in  in  16  external input word.
- wb_en  out  1  register-file write enable.
- wb_rd  out  4  write-back register index.
- wb_data  out  16  write-back data.
- flag_wb  out  2  architectural flags.
- io_out  out  16  memory-mapped output register.
- addr_err  out  1  sticky out-of-range access flag.

Behaviour:
- Reset (sampled high at a rising edge):
  - wb_en=0, wb_rd=0, wb_data=0, flag_wb=0, io_out=0, addr_err=0.
  - RAM contents are not cleared.
  - Reset overrides a simultaneous valid packet: no RAM write, no io_out update.
- Latency:
  - Packet sampled at edge N; wb_* are valid in the cycle after edge N.
  - Throughput is one packet per cycle; no stalls and no backpressure.
- valid_ex=0: wb_en=0 at the next edge. wb_rd, wb_data, flag_wb, io_out and RAM hold.
- Address decode for LOAD/STORE, where a = ans_ex:
  - a==IO_OUT_ADDR or a==IO_IN_ADDR: I/O space.
  - a < 2**ADDR_W: RAM index a[ADDR_W-1:0].
  - Otherwise out of range.
- STORE:
  - RAM target: RAM[a] <= DM_data.
  - IO_OUT_ADDR: io_out <= DM_data.
  - IO_IN_ADDR or out of range: no write; addr_err <= 1.
  - wb_en=0 regardless of wr_ex.
  - flag_wb holds.
- LOAD:
  - RAM target: wb_data <= RAM[a], synchronous read at edge N.
  - IO_IN_ADDR: wb_data <= io_in sampled at edge N.
  - IO_OUT_ADDR: wb_data <= current io_out.
  - Out of range: wb_data <= 0; addr_err <= 1.
  - wb_en <= wr_ex; wb_rd <= rd_ex.
  - flag_wb[1] <= (loaded value==0); flag_wb[0] <= 0.
- Any other opcode:
  - wb_data <= ans_ex; wb_en <= wr_ex; wb_rd <= rd_ex.
  - flag_wb <= flag_ex.
- Back-to-back STORE then LOAD to the same address (consecutive cycles): the LOAD returns the newly stored value. This follows from write at edge N and read at edge N+1; no bypass path is needed.
- addr_err is sticky; only reset clears it.
- Widths:
  - All data is DATA_W bits, no sign extension.
  - Address compare uses the full 16-bit ans_ex.

Test Plan:
- Reset high 2 cycles with valid_ex=1, op STORE, ans_ex=16'h0010, DM_data=16'hBEEF, then deassert and LOAD 16'h0010 -> wb_en=0, io_out=0, addr_err=0 during reset; the later LOAD returns the prior RAM content, not 16'hBEEF.
- STORE 16'h1234 to address 16'h0005 at cycle 1, LOAD address 16'h0005 with rd_ex=3, wr_ex=1 at cycle 2 -> cycle 3: wb_en=1, wb_rd=3, wb_data=16'h1234, flag_wb=2'b00.
- ALU op 6'b000000, ans_ex=16'h0000, flag_ex=2'b11, rd_ex=7, wr_ex=1 -> next cycle wb_data=0, wb_rd=7, wb_en=1, flag_wb=2'b11. A following STORE leaves flag_wb=2'b11.
- STORE 16'hA5A5 to 16'hFFFF, then LOAD 16'hFFFE with io_in=16'h00C3 -> io_out=16'hA5A5 after the first edge; wb_data=16'h00C3 after the second edge.
- STORE to 16'h0100 with ADDR_W=8 -> RAM unchanged and addr_err=1. addr_err stays 1 through 10 further valid ALU ops and clears only on reset.
- LOAD of a RAM word holding 0 with wr_ex=0 -> wb_en=0, wb_data=0, flag_wb=2'b10.
